// File: rtl/ingress_filter.sv
// ingress_filter: per-port ingress stage in front of the port's input FIFO.
// Captures one packet word into a one-entry holding register, checks header
// legality, writes legal words into the FIFO and drops illegal ones. Keeps
// saturating accept/drop counters and a sticky reason code for the last drop.
//
// Optional build macro:
//   INGRESS_STRICT_SRC_EN  - also require source == (1 << PORT_ID) (reason 7).
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - upstream handshake, in_data is the packet word
//   fifo_full         - FIFO cannot take a write this cycle
//   fifo_wr_en/_data  - FIFO write strobe and word (data = held word)
//   accept_cnt        - packets written, saturating
//   drop_cnt          - packets dropped, saturating
//   drop_reason       - code of the most recent drop (0 = none since reset)
module ingress_filter #(
  parameter int unsigned PACKET_WIDTH = 16,
  parameter int unsigned PORT_ID      = 0,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PACKET_WIDTH-1:0] in_data,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [PACKET_WIDTH-1:0] fifo_wr_data,
  output logic [CNT_WIDTH-1:0]    accept_cnt,
  output logic [CNT_WIDTH-1:0]    drop_cnt,
  output logic [2:0]              drop_reason
);

  localparam int unsigned FIELD_W  = 4;
  localparam int unsigned REASON_W = 3;

  localparam logic [1:0] TYPE_SDP = 2'b00;
  localparam logic [1:0] TYPE_BDP = 2'b10;
  localparam logic [1:0] TYPE_RSV = 2'b11;

  localparam logic [FIELD_W-1:0] OWN_SRC = FIELD_W'(1 << PORT_ID);

`ifdef INGRESS_STRICT_SRC_EN
  localparam bit STRICT_EN = 1'b1;
`else
  localparam bit STRICT_EN = 1'b0;
`endif

  logic                    hold_valid_q, hold_valid_d;
  logic [PACKET_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [CNT_WIDTH-1:0]    accept_cnt_q, accept_cnt_d;
  logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;
  logic [REASON_W-1:0]     drop_reason_q, drop_reason_d;

  logic [FIELD_W-1:0]  src_c, tgt_c;
  logic [1:0]          typ_c;
  logic [REASON_W-1:0] reason_c;
  logic                legal_c, drain_c, wr_c, drop_c, accept_c;

  function automatic logic is_onehot(input logic [FIELD_W-1:0] v);
    return (v != '0) && ((v & (v - FIELD_W'(1))) == '0);
  endfunction

  assign src_c = hold_data_q[3:0];
  assign tgt_c = hold_data_q[7:4];
  assign typ_c = hold_data_q[9:8];

  // Header check; earlier branches win so the lowest code is reported.
  always_comb begin
    reason_c = '0;
    if (!is_onehot(src_c))                                   reason_c = 3'd1;
    else if (tgt_c == '0)                                    reason_c = 3'd2;
    else if ((typ_c != TYPE_BDP) && ((src_c & tgt_c) != '0)) reason_c = 3'd3;
    else if ((typ_c == TYPE_SDP) && !is_onehot(tgt_c))       reason_c = 3'd4;
    else if ((typ_c == TYPE_BDP) && (tgt_c != 4'hF))         reason_c = 3'd5;
    else if (typ_c == TYPE_RSV)                              reason_c = 3'd6;
    else if (STRICT_EN && (src_c != OWN_SRC))                reason_c = 3'd7;
  end

  assign legal_c = (reason_c == '0);

  // Held word leaves the register either by a write or by a drop.
  assign drain_c  = hold_valid_q && (!legal_c || !fifo_full);
  assign wr_c     = !rst && hold_valid_q && legal_c && !fifo_full;
  assign drop_c   = hold_valid_q && !legal_c;
  assign in_ready = !rst && (!hold_valid_q || drain_c);
  assign accept_c = in_valid && in_ready;

  // Next-state for holding register and statistics.
  always_comb begin
    hold_valid_d  = hold_valid_q;
    hold_data_d   = hold_data_q;
    accept_cnt_d  = accept_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    drop_reason_d = drop_reason_q;

    if (accept_c) begin
      hold_valid_d = 1'b1;
      hold_data_d  = in_data;
    end else if (drain_c) begin
      hold_valid_d = 1'b0;
    end

    if (wr_c && (accept_cnt_q != '1)) accept_cnt_d = accept_cnt_q + CNT_WIDTH'(1);

    if (drop_c) begin
      drop_reason_d = reason_c;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State register; reset discards any held word without counting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q  <= 1'b0;
      hold_data_q   <= '0;
      accept_cnt_q  <= '0;
      drop_cnt_q    <= '0;
      drop_reason_q <= '0;
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_data_q   <= hold_data_d;
      accept_cnt_q  <= accept_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      drop_reason_q <= drop_reason_d;
    end
  end

  assign fifo_wr_en   = wr_c;
  assign fifo_wr_data = hold_data_q;
  assign accept_cnt   = accept_cnt_q;
  assign drop_cnt     = drop_cnt_q;
  assign drop_reason  = drop_reason_q;

endmodule

// File: tb/tb_ingress_filter.sv
// tb_ingress_filter: directed bench for ingress_filter (PORT_ID=0, CNT_WIDTH=4).
// Single-packet vectors come from a table; stall, full-rate saturation and
// reset-mid-stall are hand-written sequences.
module tb_ingress_filter;

  localparam int unsigned PW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned NVEC = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [PW-1:0] fifo_wr_data;
  logic [CW-1:0] accept_cnt;
  logic [CW-1:0] drop_cnt;
  logic [2:0]    drop_reason;

  ingress_filter #(.PACKET_WIDTH(PW), .PORT_ID(0), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .accept_cnt   (accept_cnt),
    .drop_cnt     (drop_cnt),
    .drop_reason  (drop_reason)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] data;
    logic          exp_wr;
    logic [2:0]    exp_reason;
  } vec_t;

  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_pass   = 0;

  int exp_acc = 0;
  int exp_drop = 0;
  int exp_rsn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; fifo_full = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // data = {payload, type[9:8], tgt[7:4], src[3:0]}
    vecs[0]  = '{16'h0021, 1'b1, 3'd0};  // SDP src1 tgt2
    vecs[1]  = '{16'h0031, 1'b0, 3'd3};  // SDP loopback
    vecs[2]  = '{16'h02F1, 1'b1, 3'd0};  // BDP tgt F
    vecs[3]  = '{16'h02E1, 1'b0, 3'd5};  // BDP tgt E
    vecs[4]  = '{16'h0321, 1'b0, 3'd6};  // reserved type
    vecs[5]  = '{16'h0043, 1'b0, 3'd1};  // src not one-hot
    vecs[6]  = '{16'h0000, 1'b0, 3'd1};  // src 0 and tgt 0: lowest code
    vecs[7]  = '{16'h0001, 1'b0, 3'd2};  // tgt 0
    vecs[8]  = '{16'h0052, 1'b0, 3'd4};  // SDP tgt not one-hot
    vecs[9]  = '{16'hFD61, 1'b1, 3'd0};  // MDP src1 tgt6 with payload
    vecs[10] = '{16'h0164, 1'b0, 3'd3};  // MDP loopback
    vecs[11] = '{16'h0343, 1'b0, 3'd1};  // reserved + bad src: code 1 wins
`ifdef INGRESS_STRICT_SRC_EN
    vecs[12] = '{16'h0012, 1'b0, 3'd7};  // src2 on port 0
`else
    vecs[12] = '{16'h0012, 1'b1, 3'd0};
`endif

    rst = 1'b1; in_valid = 1'b0; in_data = '0; fifo_full = 1'b0;

    // Reset values
    @(negedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    @(negedge clk); #1;
    check("rst_acc", 32'(accept_cnt), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_reason", 32'(drop_reason), 0);
    rst = 1'b0; #1;
    check("post_rst_ready", 32'(in_ready), 1);

    // Table: one packet every three cycles
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = vecs[i].data; fifo_full = 1'b0; #1;
      check($sformatf("v%0d_ready", i), 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0; in_data = '0; #1;
      check($sformatf("v%0d_wr_en", i), 32'(fifo_wr_en), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) check($sformatf("v%0d_wr_data", i), 32'(fifo_wr_data), 32'(vecs[i].data));
      else check($sformatf("v%0d_ready_on_drop", i), 32'(in_ready), 1);
      if (vecs[i].exp_wr) begin
        if (exp_acc < 15) exp_acc++;
      end else begin
        if (exp_drop < 15) exp_drop++;
        exp_rsn = int'(vecs[i].exp_reason);
      end
      @(negedge clk); #1;
      check($sformatf("v%0d_acc", i), 32'(accept_cnt), 32'(exp_acc));
      check($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(exp_drop));
      check($sformatf("v%0d_reason", i), 32'(drop_reason), 32'(exp_rsn));
    end

    // Stall for 5 cycles, then write and accept the next word together
    @(negedge clk);
    fifo_full = 1'b1; in_valid = 1'b1; in_data = 16'h0021; #1;
    check("stall_first_ready", 32'(in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_data = 16'h0041; #1;
      check($sformatf("stall%0d_ready", i), 32'(in_ready), 0);
      check($sformatf("stall%0d_wr_en", i), 32'(fifo_wr_en), 0);
    end
    @(negedge clk);
    fifo_full = 1'b0; #1;
    check("unstall_wr_en", 32'(fifo_wr_en), 1);
    check("unstall_wr_data", 32'(fifo_wr_data), 32'h0021);
    check("unstall_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0; #1;
    check("b2b_wr_en", 32'(fifo_wr_en), 1);
    check("b2b_wr_data", 32'(fifo_wr_data), 32'h0041);
    @(negedge clk); #1;
    check("b2b_idle_wr_en", 32'(fifo_wr_en), 0);
    if (exp_acc < 15) exp_acc++;
    if (exp_acc < 15) exp_acc++;
    check("stall_acc", 32'(accept_cnt), 32'(exp_acc));

    // 20 illegal packets at full rate: drop counter saturates at 15
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h0031; #1;
      check($sformatf("burst%0d_ready", i), 32'(in_ready), 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); #1;
    check("sat_drop", 32'(drop_cnt), 15);
    check("sat_reason", 32'(drop_reason), 3);
    check("sat_acc", 32'(accept_cnt), 0);

    // Reset while a legal word is stalled
    @(negedge clk);
    fifo_full = 1'b1; in_valid = 1'b1; in_data = 16'h0021;
    @(negedge clk);
    in_valid = 1'b0; #1;
    check("pre_rst_stall_wr", 32'(fifo_wr_en), 0);
    @(negedge clk);
    rst = 1'b1; fifo_full = 1'b0; #1;
    check("rst_stall_wr", 32'(fifo_wr_en), 0);
    check("rst_stall_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0; #1;
    check("after_rst_wr", 32'(fifo_wr_en), 0);
    check("after_rst_ready", 32'(in_ready), 1);
    check("after_rst_drop", 32'(drop_cnt), 0);
    check("after_rst_acc", 32'(accept_cnt), 0);
    check("after_rst_reason", 32'(drop_reason), 0);
    @(negedge clk); #1;
    check("after_rst_no_late_wr", 32'(fifo_wr_en), 0);
    check("after_rst_no_late_drop", 32'(drop_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ingress_filter.md
# ingress_filter

Per-port ingress stage between the port interface and the port's input FIFO. It accepts single-word packets over a valid/ready handshake and holds each one in a one-entry register. It checks header legality, writes legal packets into the FIFO, and drops illegal ones, so the downstream `switch_port` FSM never sees a loopback or malformed header. Saturating accept and drop counters plus a sticky drop-reason register support debug.

## Interface
Parameters:
- `PACKET_WIDTH`, 16: packet word width; header occupies bits [9:0].
- `PORT_ID`, 0: index 0..3 of the owning port.
- `CNT_WIDTH`, 16: width of the statistics counters.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream packet word valid.
- `in_ready` out 1: filter can take a word this cycle.
- `in_data` in PACKET_WIDTH: packet word. Fields:
  - [3:0] source, one-hot.
  - [7:4] target mask.
  - [9:8] type: 00 SDP, 01 MDP, 10 BDP, 11 reserved.
  - [15:10] payload.
- `fifo_full` in 1: input FIFO cannot accept a write this cycle.
- `fifo_wr_en` out 1: write strobe to the FIFO.
- `fifo_wr_data` out PACKET_WIDTH: word written; equals the held word.
- `accept_cnt` out CNT_WIDTH: packets written to the FIFO, saturating.
- `drop_cnt` out CNT_WIDTH: packets dropped, saturating.
- `drop_reason` out 3: reason code of the most recent drop.

## Operation
- Holding register: `hold_valid` and `hold_data`. The upstream word is captured when `in_valid && in_ready`.
- Legality is evaluated combinationally on `hold_data`. A packet is illegal if any of these holds:
  - source not one-hot: reason 1.
  - target == 0: reason 2.
  - non-BDP and (source & target) != 0, i.e. loopback: reason 3.
  - SDP and target not one-hot: reason 4.
  - BDP and target != 4'hF: reason 5.
  - type 11: reason 6.
- If several conditions hold, the lowest code wins.
- Drain condition, computed every cycle:
  - `hold_valid && legal && !fifo_full`: write to the FIFO. `fifo_wr_en` = 1 and `accept_cnt` increments.
  - `hold_valid && !legal`: drop. No write; `drop_cnt` increments; `drop_reason` is loaded with the code.
  - `hold_valid && legal && fifo_full`: stall. The word is held unchanged.
- Ready: `in_ready = !rst && (!hold_valid || drain)`. An accept and a drain in the same cycle reload the register with no bubble.
- Counters saturate at all-ones and never wrap.
- `drop_reason` holds its value until the next drop.
- `fifo_wr_data` is driven from `hold_data` at all times. It is meaningful only while `fifo_wr_en` = 1.
- `fifo_wr_en` is never asserted for an illegal packet or while `fifo_full` = 1.

## Timing
- Reset values:
  - `hold_valid` = 0, `hold_data` = 0.
  - `fifo_wr_en` = 0, `in_ready` = 0 while `rst` is high.
  - `accept_cnt` = 0, `drop_cnt` = 0, `drop_reason` = 0.
- First cycle after `rst` deasserts: `in_ready` = 1.
- Latency: a word accepted at edge N is written (`fifo_wr_en` = 1) in cycle N+1 if legal and the FIFO is not full. It is dropped in cycle N+1 if illegal.
- Throughput: one packet per cycle while the FIFO is not full, including back-to-back illegal packets.
- `fifo_wr_en` and `in_ready` are combinational from registered state plus `fifo_full`. There is no path from `in_valid` to `in_ready`.
- Reset mid-stall: the held word is discarded without a write or a drop count.
- `fifo_full` deasserting while a word is held: the write occurs in that same cycle.

## Configuration
- `INGRESS_STRICT_SRC_EN`
  - Defined: an additional check, source != (1 << PORT_ID) gives reason 7. It is evaluated after codes 1-6.
  - Undefined: source only needs to be one-hot; code 7 is never produced.

## Test plan
- Reset, then PORT_ID=0 sends SDP src=0001 tgt=0010 with the FIFO not full -> `fifo_wr_en` = 1 one cycle after accept, data matches, `accept_cnt` = 1.
- SDP src=0001 tgt=0011 (loopback) -> no write; `drop_cnt` = 1; `drop_reason` = 3; `in_ready` stays 1.
- `fifo_full` = 1 for 5 cycles with a legal word held -> `in_ready` = 0 and no write for those 5 cycles. Write occurs in the cycle `fifo_full` drops; the next word is accepted in the same cycle.
- BDP src=0001 tgt=1111 accepted; BDP tgt=1110 dropped with reason 5; type 11 dropped with reason 6.
- `INGRESS_STRICT_SRC_EN` defined, PORT_ID=2, SDP src=0001 tgt=0010 -> dropped with reason 7. Undefined -> written.
- CNT_WIDTH=4, 20 consecutive illegal packets at full rate -> `drop_cnt` stops at 15. Assert `rst` mid-stall -> all counters 0 and no write.
